// File: rtl/page_walk_arbiter.sv
// page_walk_arbiter: shares one hardware page walker between fetch, load AGU
// and store AGU. Round-robin grant, latched request, walker handshake, tagged
// result broadcast.
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous reset, active low
//   IN_rq        NUM_RQ packed PageWalkRq words, requester i at [i*59 +: 59]
//   OUT_walk     PageWalkRq presented to the walker
//   IN_walkReady walker accepts OUT_walk this cycle
//   IN_walkRes   walker result
//   OUT_pw       PageWalkRes broadcast to all requesters
//
// PageWalkRq (59 bits):
//   [58] valid  [57:36] rootPPN  [35:4] addr
//   [3] supervUserMemory  [2] makeExecReadable  [1:0] priv
// Walker result (25 bits):
//   [24] valid  [23:2] ppn  [1] pageFault  [0] isSuperPage
// PageWalkRes (26+RQ_ID_W bits), MSB first:
//   busy, rqID[RQ_ID_W-1:0], valid, ppn[21:0], pageFault, isSuperPage
module page_walk_arbiter #(
    parameter int NUM_RQ  = 3,
    parameter int RQ_ID_W = 2,
    localparam int RQ_W   = 59,
    localparam int RES_W  = 25,
    localparam int PW_W   = RQ_ID_W + 26
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RQ*RQ_W-1:0]   IN_rq,
    output logic [RQ_W-1:0]          OUT_walk,
    input  logic                     IN_walkReady,
    input  logic [RES_W-1:0]         IN_walkRes,
    output logic [PW_W-1:0]          OUT_pw
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [RQ_ID_W-1:0]   r_rrPtr, w_rrPtr_nxt;
    logic [RQ_W-1:0]      r_walk, w_walk_nxt;
    logic                 r_busy, w_busy_nxt;
    logic [RQ_ID_W-1:0]   r_rqID, w_rqID_nxt;
    logic                 r_pwValid, w_pwValid_nxt;
    logic [21:0]          r_ppn, w_ppn_nxt;
    logic                 r_pf, w_pf_nxt;
    logic                 r_sp, w_sp_nxt;

    logic [RQ_W-1:0]      w_rq [NUM_RQ];
    logic [NUM_RQ-1:0]    w_rqv;
    logic                 w_found;
    logic [RQ_ID_W-1:0]   w_winner;
    logic [RQ_ID_W:0]     w_sum;

    logic                 w_res_v;
    logic [21:0]          w_res_ppn;
    logic                 w_res_pf;
    logic                 w_res_sp;

    assign w_res_v   = IN_walkRes[24];
    assign w_res_ppn = IN_walkRes[23:2];
    assign w_res_pf  = IN_walkRes[1];
    assign w_res_sp  = IN_walkRes[0];

    for (genvar g = 0; g < NUM_RQ; g++) begin : g_unpack
        assign w_rq[g]  = IN_rq[g*RQ_W +: RQ_W];
        assign w_rqv[g] = IN_rq[g*RQ_W + RQ_W - 1];
    end

    // First valid requester scanning upward from rrPtr, with wrap-around.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_sum    = '0;
        for (int i = 0; i < NUM_RQ; i++) begin
            w_sum = {1'b0, r_rrPtr} + (RQ_ID_W+1)'(i);
            if (w_sum >= (RQ_ID_W+1)'(NUM_RQ))
                w_sum = w_sum - (RQ_ID_W+1)'(NUM_RQ);
            if (!w_found && w_rqv[w_sum[RQ_ID_W-1:0]]) begin
                w_found  = 1'b1;
                w_winner = w_sum[RQ_ID_W-1:0];
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_rrPtr_nxt   = r_rrPtr;
        w_walk_nxt    = r_walk;
        w_busy_nxt    = r_busy;
        w_rqID_nxt    = r_rqID;
        w_pwValid_nxt = 1'b0;
        w_ppn_nxt     = r_ppn;
        w_pf_nxt      = r_pf;
        w_sp_nxt      = r_sp;
        unique case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_walk_nxt  = w_rq[w_winner];
                    w_busy_nxt  = 1'b1;
                    w_rqID_nxt  = w_winner;
                    w_state_nxt = S_REQ;
                    if (w_winner == RQ_ID_W'(NUM_RQ - 1))
                        w_rrPtr_nxt = '0;
                    else
                        w_rrPtr_nxt = w_winner + 1'b1;
                end
            end
            S_REQ: begin
                // Requester inputs are not looked at: a flush cannot cancel.
                if (IN_walkReady) begin
                    w_walk_nxt[RQ_W-1] = 1'b0;
                    w_state_nxt        = S_WAIT;
                end
            end
            S_WAIT: begin
                if (w_res_v) begin
                    w_pwValid_nxt = 1'b1;
                    w_ppn_nxt     = w_res_ppn;
                    w_pf_nxt      = w_res_pf;
                    w_sp_nxt      = w_res_sp;
                    w_busy_nxt    = 1'b0;
                    w_state_nxt   = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_rrPtr   <= '0;
            r_walk    <= '0;
            r_busy    <= 1'b0;
            r_rqID    <= '0;
            r_pwValid <= 1'b0;
            r_ppn     <= '0;
            r_pf      <= 1'b0;
            r_sp      <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_rrPtr   <= w_rrPtr_nxt;
            r_walk    <= w_walk_nxt;
            r_busy    <= w_busy_nxt;
            r_rqID    <= w_rqID_nxt;
            r_pwValid <= w_pwValid_nxt;
            r_ppn     <= w_ppn_nxt;
            r_pf      <= w_pf_nxt;
            r_sp      <= w_sp_nxt;
        end
    end

    assign OUT_walk = r_walk;
    assign OUT_pw   = {r_busy, r_rqID, r_pwValid, r_ppn, r_pf, r_sp};

    // Protocol checks: stray results are dropped, stray readies ignored.
    always @(posedge clk) begin
        if (rst) begin
            assert (!(w_res_v && r_state != S_WAIT));
            assert (!(IN_walkReady && r_state != S_REQ));
        end
    end

endmodule

// File: tb/tb_page_walk_arbiter.sv
// tb_page_walk_arbiter: directed bench for page_walk_arbiter with a result
// scoreboard and a simple walker model driven from one initial block.
module tb_page_walk_arbiter;

    logic          clk;
    logic          rst;
    logic [176:0]  in_rq;
    logic [58:0]   out_walk;
    logic          walkReady;
    logic [24:0]   walkRes;
    logic [27:0]   out_pw;

    logic          rqv  [3];
    logic [21:0]   rppn [3];
    logic [31:0]   raddr[3];
    logic          su   [3];
    logic          mxr  [3];
    logic [1:0]    prv  [3];

    logic          res_v;
    logic [21:0]   res_ppn;
    logic          res_pf;
    logic          res_sp;

    logic [25:0]   sb[$];
    int            n_pass;
    int            n_total;

    page_walk_arbiter #(.NUM_RQ(3), .RQ_ID_W(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .IN_rq        (in_rq),
        .OUT_walk     (out_walk),
        .IN_walkReady (walkReady),
        .IN_walkRes   (walkRes),
        .OUT_pw       (out_pw)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        in_rq = '0;
        for (int i = 0; i < 3; i++)
            in_rq[i*59 +: 59] = {rqv[i], rppn[i], raddr[i],
                                 su[i], mxr[i], prv[i]};
    end

    assign walkRes = {res_v, res_ppn, res_pf, res_sp};

    wire        pw_busy  = out_pw[27];
    wire [1:0]  pw_id    = out_pw[26:25];
    wire        pw_valid = out_pw[24];
    wire [21:0] pw_ppn   = out_pw[23:2];
    wire        pw_pf    = out_pw[1];
    wire        pw_sp    = out_pw[0];

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [58:0] exp_word(input int id);
        return {1'b1, rppn[id], raddr[id], su[id], mxr[id], prv[id]};
    endfunction

    // Walker model: waits for a grant, stalls ready, then returns a result.
    task automatic walk(input int id, input int rdy_dly, input int res_dly,
                        input logic [21:0] ppn, input logic pf,
                        input logic sp);
        logic [58:0] w0;
        logic [25:0] r;
        int n;
        n = 0;
        while (!pw_busy && n < 20) begin
            tick();
            n++;
        end
        chk("grant_busy", pw_busy, 1);
        chk("grant_id", pw_id, id);
        chk("walk_word", out_walk, exp_word(id));
        w0 = out_walk;
        for (int k = 0; k < rdy_dly; k++) begin
            tick();
            chk("stall_word", out_walk, w0);
            chk("stall_id", pw_id, id);
        end
        walkReady = 1'b1;
        tick();
        walkReady = 1'b0;
        chk("walk_drop", out_walk[58], 0);
        chk("wait_busy", pw_busy, 1);
        for (int k = 0; k < res_dly; k++) begin
            tick();
            chk("wait_busy", pw_busy, 1);
        end
        res_v   = 1'b1;
        res_ppn = ppn;
        res_pf  = pf;
        res_sp  = sp;
        sb.push_back({2'(id), ppn, pf, sp});
        tick();
        res_v = 1'b0;
        if (sb.size() == 0) begin
            chk("sb_empty", 1, 0);
        end else begin
            r = sb.pop_front();
            chk("res_valid", pw_valid, 1);
            chk("res_busy", pw_busy, 0);
            chk("res_id", pw_id, r[25:24]);
            chk("res_ppn", pw_ppn, r[23:2]);
            chk("res_pf", pw_pf, r[1]);
            chk("res_sp", pw_sp, r[0]);
            tick();
            chk("res_pulse", pw_valid, 0);
            chk("res_hold", pw_ppn, r[23:2]);
        end
    endtask

    initial begin
        n_pass    = 0;
        n_total   = 0;
        rst       = 1'b0;
        walkReady = 1'b0;
        res_v     = 1'b0;
        res_ppn   = '0;
        res_pf    = 1'b0;
        res_sp    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rqv[i]  = 1'b0;
            rppn[i] = 22'h10000 + 22'(i * 22'h111);
            su[i]   = i[0];
            mxr[i]  = ~i[0];
            prv[i]  = 2'(i + 1);
        end
        raddr[0] = 32'h1000_0a00;
        raddr[1] = 32'h8040_1234;
        raddr[2] = 32'hc0de_0f00;

        tick();
        tick();
        chk("rst_pw", out_pw, 0);
        chk("rst_walk", out_walk, 0);
        rst = 1'b1;
        tick();
        chk("idle_pw", out_pw, 0);

        // round robin with all three requesting: 0,1,2,0
        rqv[0] = 1'b1;
        rqv[1] = 1'b1;
        rqv[2] = 1'b1;
        walk(0, 0, 1, 22'h0aaaa, 1'b0, 1'b0);
        walk(1, 1, 0, 22'h0bbbb, 1'b0, 1'b0);
        walk(2, 0, 2, 22'h0cccc, 1'b0, 1'b0);
        rqv[0] = 1'b0;
        rqv[1] = 1'b0;
        rqv[2] = 1'b0;
        walk(0, 0, 0, 22'h0dddd, 1'b0, 1'b0);

        // rrPtr=1, 2 and 0 raised together: 2 then 0
        rqv[0] = 1'b1;
        rqv[2] = 1'b1;
        walk(2, 0, 1, 22'h01234, 1'b0, 1'b0);
        rqv[0] = 1'b0;
        rqv[2] = 1'b0;
        walk(0, 0, 1, 22'h04321, 1'b0, 1'b0);

        // single request from load AGU
        rqv[1] = 1'b1;
        tick();
        rqv[1] = 1'b0;
        walk(1, 0, 2, 22'h00123, 1'b0, 1'b0);
        chk("single_idle", pw_busy, 0);

        // flush: requester 2 drops valid while in REQ
        rqv[2] = 1'b1;
        tick();
        rqv[2] = 1'b0;
        walk(2, 2, 1, 22'h2f00d, 1'b0, 1'b1);

        // ready stall of 6 cycles with another requester pending
        rqv[0] = 1'b1;
        rqv[1] = 1'b1;
        walk(0, 6, 0, 22'h15555, 1'b0, 1'b0);
        rqv[0] = 1'b0;
        rqv[1] = 1'b0;
        walk(1, 0, 0, 22'h16666, 1'b0, 1'b0);

        // fault passthrough
        tick();
        rqv[0] = 1'b1;
        tick();
        rqv[0] = 1'b0;
        walk(0, 0, 1, 22'h3abcd, 1'b1, 1'b1);

        // reset asserted while in WAIT, walker result during reset
        rqv[1] = 1'b1;
        tick();
        rqv[1] = 1'b0;
        chk("rw_grant", pw_busy, 1);
        walkReady = 1'b1;
        tick();
        walkReady = 1'b0;
        res_v   = 1'b1;
        res_ppn = 22'h3ffff;
        res_pf  = 1'b1;
        res_sp  = 1'b1;
        #2 rst = 1'b0;
        #1;
        chk("rw_async_pw", out_pw, 0);
        chk("rw_async_walk", out_walk, 0);
        tick();
        rst   = 1'b1;
        res_v = 1'b0;
        chk("rw_no_res", out_pw, 0);
        tick();
        chk("rw_still_idle", out_pw, 0);
        rqv[2] = 1'b1;
        tick();
        rqv[2] = 1'b0;
        walk(2, 0, 0, 22'h07777, 1'b0, 1'b0);

        chk("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $fatal(1, "FAIL timeout observed=running expected=finished");
    end

endmodule
